// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared types and constants for the nibble-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

  // Slice width handled by the combinational nibble adder
  localparam int NIB_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_nibble.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder
// Description : Combinational 4-bit ripple-carry adder built from full-adder
//               cells. Exports the carry into bit 3 so the parent can form
//               signed overflow for the most significant slice.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c3
);

  // w_c[k] is the carry into bit k; w_c[NIB_W] is the carry out
  logic [NIB_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < NIB_W; k++) begin : g_fa
    // One full-adder cell per bit
    assign o_sum[k]  = i_a[k] ^ i_b[k] ^ w_c[k];
    assign w_c[k+1]  = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
  end

  assign o_cout = w_c[NIB_W];
  assign o_c3   = w_c[NIB_W-1];

endmodule : nibble_adder
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : WIDTH-bit adder that reuses one 4-bit nibble adder over
//               WIDTH/4 cycles, LSB slice first, with valid/ready handshakes
//               on both the operand and the result side.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_out_valid;

  logic [NIB_W-1:0]   w_nib_a;
  logic [NIB_W-1:0]   w_nib_b;
  logic [NIB_W-1:0]   w_nib_sum;
  logic               w_nib_cout;
  logic               w_nib_c3;

  // Current slice of each operand, selected by the slice index
  assign w_nib_a = r_a[r_idx*NIB_W +: NIB_W];
  assign w_nib_b = r_b[r_idx*NIB_W +: NIB_W];

  nibble_adder u_nibble_adder (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout),
    .o_c3   (w_nib_c3)
  );

  // Controller, slice sequencing and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_sum[r_idx*NIB_W +: NIB_W] <= w_nib_sum;
          r_carry                     <= w_nib_cout;
          r_idx                       <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            // Signed overflow: carry into the sign bit differs from carry out
            r_cout      <= w_nib_cout;
            r_ovf       <= w_nib_c3 ^ w_nib_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is a pure decode of the state register
  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule : nibble_serial_adder
`default_nettype wire
